// File: rtl/counter_cmd_pkg.sv
// Shared types for the decade-counter command sequencer.
package counter_cmd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_RUN   = 2'b10,
        OP_HOLD  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module cycle_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            cnt_q <= load_val;
            zero  <= (load_val == '0);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
            zero  <= (cnt_q == W'(1));
        end
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer driving a decade counter's MR/Load/Enable/P, with a shadow of the counter value.
module counter_cmd_sequencer
    import counter_cmd_pkg::*;
#(
    parameter int unsigned MAX_VAL    = 9,
    parameter int unsigned RUN_W      = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RUN_W-1:0]   cmd_data,
    output logic               MR,
    output logic               Load,
    output logic               Enable,
    output logic [DIGIT_W-1:0] P,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DIGIT_W-1:0] exp_q
);

    state_e               state_q, state_d;
    logic                 mr_d, load_d, enable_d, busy_d, done_d, err_d;
    logic [DIGIT_W-1:0]   p_d, exp_d, exp_inc;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [RUN_W-1:0]     cnt_val;

    // Commands are only taken in IDLE; the counter loads n-1 so zero marks the last active cycle.
    assign cmd_ready = (state_q == IDLE) && rst_n;
    assign exp_inc   = (exp_q == DIGIT_W'(MAX_VAL)) ? '0 : exp_q + DIGIT_W'(1);

    cycle_down_counter #(.W(RUN_W)) u_len (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            MR      <= 1'b0;
            Load    <= 1'b0;
            Enable  <= 1'b0;
            P       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            MR      <= mr_d;
            Load    <= load_d;
            Enable  <= enable_d;
            P       <= p_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mr_d     = 1'b0;
        load_d   = 1'b0;
        enable_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        p_d      = P;
        exp_d    = exp_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        OP_CLEAR: begin
                            state_d  = S_CLEAR;
                            mr_d     = 1'b1;
                            cnt_load = 1'b1;
                            cnt_val  = RUN_W'(CLR_CYCLES - 1);
                        end
                        OP_LOAD: begin
                            if (cmd_data[DIGIT_W-1:0] <= DIGIT_W'(MAX_VAL)) begin
                                state_d = S_LOAD;
                                load_d  = 1'b1;
                                p_d     = cmd_data[DIGIT_W-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RUN, OP_HOLD: begin
                            if (cmd_data == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d  = (cmd_op_e'(cmd_op) == OP_RUN) ? S_RUN : S_HOLD;
                                enable_d = (cmd_op_e'(cmd_op) == OP_RUN);
                                cnt_load = 1'b1;
                                cnt_val  = cmd_data - RUN_W'(1);
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            S_CLEAR: begin
                exp_d = '0;
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    mr_d    = 1'b1;
                    cnt_dec = 1'b1;
                end
            end
            S_LOAD: begin
                exp_d   = P;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            S_RUN: begin
                exp_d = exp_inc;
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    enable_d = 1'b1;
                    cnt_dec  = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench for counter_cmd_sequencer: directed scenarios plus randomized command streams.
module tb_counter_cmd_sequencer;

    localparam int MOD = 10;
    localparam int CLR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       MR, Load, Enable, busy, done, err;
    logic [3:0] P, exp_q;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_exp = 4'd0;
    logic [3:0] m_p   = 4'd0;

    counter_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .MR        (MR),
        .Load      (Load),
        .Enable    (Enable),
        .P         (P),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .exp_q     (exp_q)
    );

    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0({MR, Load, Enable}))
        else begin errors++; $display("FAIL onehot0: MR=%b Load=%b Enable=%b", MR, Load, Enable); end

    assert property (@(posedge clk) disable iff (!rst_n) Load |=> (exp_q == $past(P)))
        else begin errors++; $display("FAIL load_exp: exp_q=%0d required %0d", exp_q, $past(P)); end

    // Every accepted command is eventually followed by a done pulse, unless reset intervenes.
    initial begin
        bit pend = 0;
        int age  = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pend = 0;
                age  = 0;
            end else begin
                if (cmd_valid && cmd_ready && (!pend || done)) begin
                    pend = 1;
                    age  = 0;
                end else if (done) begin
                    pend = 0;
                end else if (pend) begin
                    age++;
                end
                if (pend && age == 400) begin
                    errors++;
                    $display("FAIL eventual_done: no done within %0d cycles, required one", age);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] vec(input logic mr, ld, en, dn, er, bz, rdy,
                                        input logic [3:0] p, e);
        return {mr, ld, en, dn, er, bz, rdy, p, e};
    endfunction

    // Issue one command and check every cycle until it completes; optionally keep the next one valid meanwhile.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input bit hold,
                          input logic [1:0] nop, input logic [7:0] ndata);
        int waited = 0;
        int len;
        int n = int'(data);
        logic [3:0] d  = data[3:0];
        logic [3:0] e0 = m_exp;
        logic [14:0] want, got;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept op=%0d: cmd_ready=%b required 1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        case (op)
            2'd0:    len = CLR + 1;
            2'd1:    len = (d <= 4'd9) ? 2 : 1;
            default: len = (n == 0) ? 1 : n + 1;
        endcase
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            want = vec(0, 0, 0, 1, 0, 0, 1, m_p, e0);
            case (op)
                2'd0: if (j <= CLR) want = vec(1, 0, 0, 0, 0, 1, 0, m_p, (j == 1) ? e0 : 4'd0);
                      else          want = vec(0, 0, 0, 1, 0, 0, 1, m_p, 4'd0);
                2'd1: if (d > 4'd9) want = vec(0, 0, 0, 0, 1, 0, 1, m_p, e0);
                      else if (j == 1) want = vec(0, 1, 0, 0, 0, 1, 0, d, e0);
                      else             want = vec(0, 0, 0, 1, 0, 0, 1, d, d);
                2'd2: if (j <= n) want = vec(0, 0, 1, 0, 0, 1, 0, m_p, 4'((int'(e0) + j - 1) % MOD));
                      else        want = vec(0, 0, 0, 1, 0, 0, 1, m_p, 4'((int'(e0) + n) % MOD));
                default: if (j <= n) want = vec(0, 0, 0, 0, 0, 1, 0, m_p, e0);
            endcase
            got = {MR, Load, Enable, done, err, busy, cmd_ready, P, exp_q};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cmd op=%0d data=%0d cycle k+%0d: {MR,Load,En,done,err,busy,rdy,P,exp_q}=%b required %b",
                         op, data, j, got, want);
            end
            if (j == 1) begin
                cmd_valid = hold;
                cmd_op    = nop;
                cmd_data  = ndata;
            end
        end
        case (op)
            2'd0: m_exp = 4'd0;
            2'd1: if (d <= 4'd9) begin m_p = d; m_exp = d; end
            2'd2: m_exp = 4'((int'(e0) + n) % MOD);
            default: ;
        endcase
    endtask

    task automatic check_idle(input string name);
        logic [14:0] got, want;
        got  = {MR, Load, Enable, done, err, busy, cmd_ready, P, exp_q};
        want = vec(0, 0, 0, 0, 0, 0, 1, m_p, m_exp);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs=%b required %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {MR, Load, Enable, done, err, busy, cmd_ready, P, exp_q};
        checks++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: outputs=%b required %b", got, 15'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset_idle");
    endtask

    task automatic test_load();
        do_cmd(2'd1, 8'd7, 0, 2'd0, 8'd0);
    endtask

    task automatic test_run();
        do_cmd(2'd2, 8'd12, 0, 2'd0, 8'd0);
        checks++;
        if (exp_q !== 4'd9) begin
            errors++;
            $display("FAIL run12_final: exp_q=%0d required 9", exp_q);
        end
    endtask

    task automatic test_load_illegal();
        do_cmd(2'd1, 8'd10, 0, 2'd0, 8'd0);
        @(negedge clk);
        check_idle("illegal_load_after");
        do_cmd(2'd1, 8'hF3, 0, 2'd0, 8'd0);
    endtask

    task automatic test_zero_hold();
        do_cmd(2'd2, 8'd0, 0, 2'd0, 8'd0);
        do_cmd(2'd3, 8'd3, 0, 2'd0, 8'd0);
    endtask

    task automatic test_back_to_back();
        do_cmd(2'd0, 8'd0, 1, 2'd1, 8'd4);
        do_cmd(2'd1, 8'd4, 1, 2'd2, 8'd1);
        do_cmd(2'd2, 8'd1, 0, 2'd0, 8'd0);
    endtask

    task automatic test_random();
        logic [1:0] ops [41];
        logic [7:0] dat [41];
        bit hold;
        for (int i = 0; i < 41; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            if (ops[i] >= 2'd2) dat[i] = 8'($urandom_range(0, 24));
            else                dat[i] = 8'($urandom);
        end
        for (int i = 0; i < 40; i++) begin
            hold = ($urandom_range(0, 1) == 1);
            do_cmd(ops[i], dat[i], hold, ops[i+1], dat[i+1]);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    cmd_op   = 2'($urandom);
                    cmd_data = 8'($urandom);
                    @(negedge clk);
                    check_idle("random_gap_idle");
                end
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [14:0] got, want;
        logic [3:0] e0;
        do_cmd(2'd1, 8'd6, 0, 2'd0, 8'd0);
        e0 = m_exp;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_data  = 8'd20;
        @(posedge clk);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) cmd_valid = 1'b0;
            got  = {MR, Load, Enable, done, err, busy, cmd_ready, P, exp_q};
            want = vec(0, 0, 1, 0, 0, 1, 0, m_p, 4'((int'(e0) + j - 1) % MOD));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL midrun cycle k+%0d: outputs=%b required %b", j, got, want);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        got = {MR, Load, Enable, done, err, busy, cmd_ready, P, exp_q};
        checks++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL midrun_reset: outputs=%b required %b", got, 15'd0);
        end
        rst_n = 1'b1;
        m_exp = 4'd0;
        m_p   = 4'd0;
        @(negedge clk);
        check_idle("ready_after_reset");
        do_cmd(2'd2, 8'd3, 0, 2'd0, 8'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 8'd0;
        @(negedge clk);
        test_reset();
        test_load();
        test_run();
        test_load_illegal();
        test_zero_hold();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
